// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: axis timing record, standard 640-wide presets and decode helpers
package vga_timing_pkg;
    typedef struct packed {
        logic [15:0] vis;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_axis_t;
    localparam vga_axis_t VGA_H_640 = '{vis: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
    localparam vga_axis_t VGA_V_480 = '{vis: 16'd480, fp: 16'd10, sync: 16'd2, bp: 16'd33};
    localparam vga_axis_t VGA_V_400 = '{vis: 16'd400, fp: 16'd12, sync: 16'd2, bp: 16'd35};
    function automatic logic [15:0] axis_total(vga_axis_t a);
        return a.vis + a.fp + a.sync + a.bp;
    endfunction
    function automatic logic in_sync(logic [15:0] cnt, vga_axis_t a);
        return cnt >= a.vis + a.fp && cnt < a.vis + a.fp + a.sync;
    endfunction
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: run/mode control into the generator and raster timing out of it
interface vga_timing_if #(parameter int CNT_W = 10);
    logic en, mode_sel, mode_act, pixel_tick, hsync, vsync, display_en, line_start, frame_start;
    logic [CNT_W-1:0] x_coor, y_coor;
    modport master(input en, mode_sel,
                   output mode_act, pixel_tick, hsync, vsync, display_en, x_coor, y_coor, line_start, frame_start);
    modport slave(output en, mode_sel,
                  input mode_act, pixel_tick, hsync, vsync, display_en, x_coor, y_coor, line_start, frame_start);
endinterface

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen: divides clk down to a registered one-clk pixel strobe
module pixel_tick_gen #(parameter int PIX_DIV = 4) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(PIX_DIV - 1);
    logic [DW-1:0] div_q, div_d;
    logic tick_q;
    assign div_d = div_q == LAST ? '0 : div_q + 1'b1;
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else if (en) begin
            div_q  <= div_d;
            tick_q <= div_d == LAST;
        end
    end
    assign tick = tick_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: H/V raster counters with frame-wrap mode latch and registered decode
module vga_timing_gen import vga_timing_pkg::*; #(
    parameter int PIX_DIV = 4,
    parameter int CNT_W   = 10,
    parameter int H_VIS   = int'(VGA_H_640.vis),
    parameter int H_FP    = int'(VGA_H_640.fp),
    parameter int H_SYNC  = int'(VGA_H_640.sync),
    parameter int H_BP    = int'(VGA_H_640.bp),
    parameter int V0_VIS  = int'(VGA_V_480.vis),
    parameter int V0_FP   = int'(VGA_V_480.fp),
    parameter int V0_SYNC = int'(VGA_V_480.sync),
    parameter int V0_BP   = int'(VGA_V_480.bp),
    parameter int V1_VIS  = int'(VGA_V_400.vis),
    parameter int V1_FP   = int'(VGA_V_400.fp),
    parameter int V1_SYNC = int'(VGA_V_400.sync),
    parameter int V1_BP   = int'(VGA_V_400.bp),
    parameter bit HS_POL  = 1'b0,
    parameter bit VS0_POL = 1'b0,
    parameter bit VS1_POL = 1'b1
) (
    input logic clk,
    input logic reset,
    vga_timing_if.master vga
);
    localparam vga_axis_t H  = '{vis: 16'(H_VIS), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
    localparam vga_axis_t V0 = '{vis: 16'(V0_VIS), fp: 16'(V0_FP), sync: 16'(V0_SYNC), bp: 16'(V0_BP)};
    localparam vga_axis_t V1 = '{vis: 16'(V1_VIS), fp: 16'(V1_FP), sync: 16'(V1_SYNC), bp: 16'(V1_BP)};
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(axis_total(H) - 16'd1);
    localparam logic [CNT_W-1:0] V0_LAST = CNT_W'(axis_total(V0) - 16'd1);
    localparam logic [CNT_W-1:0] V1_LAST = CNT_W'(axis_total(V1) - 16'd1);
    logic tick, adv, h_wrap, v_wrap, mode_q, mode_d, v_pol;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, fs_q;
    vga_axis_t v_ax;
    pixel_tick_gen #(.PIX_DIV(PIX_DIV)) u_tick (.clk(clk), .reset(reset), .en(vga.en), .tick(tick));
    // Decode from next-state values so every output lines up with x_coor/y_coor
    always_comb begin
        adv    = tick & vga.en;
        h_wrap = h_q == H_LAST;
        v_wrap = v_q == (mode_q ? V1_LAST : V0_LAST);
        h_d    = adv ? (h_wrap ? '0 : h_q + 1'b1) : h_q;
        v_d    = adv && h_wrap ? (v_wrap ? '0 : v_q + 1'b1) : v_q;
        mode_d = adv && h_wrap && v_wrap ? vga.mode_sel : mode_q;
        v_ax   = mode_d ? V1 : V0;
        v_pol  = mode_d ? VS1_POL : VS0_POL;
        hs_d   = in_sync(16'(h_d), H) ? HS_POL : !HS_POL;
        vs_d   = in_sync(16'(v_d), v_ax) ? v_pol : !v_pol;
        de_d   = 16'(h_d) < H.vis && 16'(v_d) < v_ax.vis;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q    <= H_LAST;
            v_q    <= vga.mode_sel ? V1_LAST : V0_LAST;
            mode_q <= vga.mode_sel;
            hs_q   <= !HS_POL;
            vs_q   <= !(vga.mode_sel ? VS1_POL : VS0_POL);
            de_q   <= 1'b0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            mode_q <= mode_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            ls_q   <= adv && h_wrap;
            fs_q   <= adv && h_wrap && v_wrap;
        end
    end
    assign vga.mode_act    = mode_q;
    assign vga.pixel_tick  = tick;
    assign vga.hsync       = hs_q;
    assign vga.vsync       = vs_q;
    assign vga.display_en  = de_q;
    assign vga.x_coor      = h_q;
    assign vga.y_coor      = v_q;
    assign vga.line_start  = ls_q;
    assign vga.frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: small-raster DUT against a linear-pixel-index model, plus a full-size PIX_DIV=1 DUT
module tb_vga_timing_gen;
    localparam int HT = 25;
    logic clk = 1'b0, rst_a = 1'b1, rst_b = 1'b1;
    always #5 clk = ~clk;
    vga_timing_if #(.CNT_W(10)) va();
    vga_timing_if #(.CNT_W(10)) vb();
    vga_timing_gen #(.PIX_DIV(4), .CNT_W(10), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V0_VIS(12), .V0_FP(2), .V0_SYNC(2), .V0_BP(3), .V1_VIS(10), .V1_FP(1), .V1_SYNC(2), .V1_BP(4),
        .HS_POL(1'b0), .VS0_POL(1'b0), .VS1_POL(1'b1)) dut_a (.clk(clk), .reset(rst_a), .vga(va));
    vga_timing_gen #(.PIX_DIV(1)) dut_b (.clk(clk), .reset(rst_b), .vga(vb));

    int checks = 0, errors = 0;
    int m_div, m_p, m_mode, b_cyc;
    bit m_ls, m_fs, m_valid = 1'b0;

    function automatic int vt(int m);
        return m != 0 ? 17 : 19;
    endfunction

    // Model: position is a linear pixel index within the current frame
    always @(posedge clk) begin
        bit adv;
        if (rst_a) begin
            m_div = 0; m_mode = int'(va.mode_sel); m_p = HT * vt(m_mode) - 1;
            m_ls = 0; m_fs = 0; m_valid = 1;
        end else if (va.en) begin
            adv = m_div == 3;
            m_div = (m_div + 1) % 4;
            m_ls = 0; m_fs = 0;
            if (adv) begin
                m_p++;
                if (m_p == HT * vt(m_mode)) begin m_p = 0; m_mode = int'(va.mode_sel); end
                m_ls = m_p % HT == 0;
                m_fs = m_p == 0;
            end
        end else begin
            m_ls = 0; m_fs = 0;
        end
    end

    always @(negedge clk) begin
        int x, y;
        logic hs, vs, de;
        logic [26:0] got, exp;
        if (m_valid) begin
            x = m_p % HT; y = m_p / HT;
            hs = (x >= 18 && x < 22) ? 1'b0 : 1'b1;
            vs = m_mode != 0 ? ((y >= 11 && y < 13) ? 1'b1 : 1'b0) : ((y >= 14 && y < 16) ? 1'b0 : 1'b1);
            de = x < 16 && y < (m_mode != 0 ? 10 : 12);
            exp = {m_div == 3, m_mode != 0, hs, vs, de, m_ls, m_fs, 10'(x), 10'(y)};
            got = {va.pixel_tick, va.mode_act, va.hsync, va.vsync, va.display_en, va.line_start, va.frame_start, va.x_coor, va.y_coor};
            checks++;
            if (got !== exp) begin
                errors++;
                if (errors < 20)
                    $display("FAIL raster t=%0t got tick/mode/hs/vs/de/ls/fs=%b x=%0d y=%0d required %b x=%0d y=%0d",
                             $time, got[26:20], got[19:10], got[9:0], exp[26:20], exp[19:10], exp[9:0]);
            end
        end
    end

    always @(posedge clk) b_cyc = rst_b ? 0 : b_cyc + 1;

    // Full-size PIX_DIV=1 raster: pixel n after release is (n-2) mod 800 on line (n-2)/800
    always @(negedge clk) begin
        int x, y;
        logic [26:0] got, exp;
        if (!rst_b && b_cyc >= 1) begin
            x = b_cyc >= 2 ? (b_cyc - 2) % 800 : 799;
            y = b_cyc >= 2 ? (b_cyc - 2) / 800 : 524;
            exp = {1'b1, 1'b0, !(x >= 656 && x < 752), !(y >= 490 && y < 492), x < 640 && y < 480,
                   b_cyc >= 2 && x == 0, b_cyc == 2, 10'(x), 10'(y)};
            got = {vb.pixel_tick, vb.mode_act, vb.hsync, vb.vsync, vb.display_en, vb.line_start, vb.frame_start, vb.x_coor, vb.y_coor};
            checks++;
            if (got !== exp) begin
                errors++;
                if (errors < 20)
                    $display("FAIL div1 cyc=%0d got %b x=%0d y=%0d required %b x=%0d y=%0d",
                             b_cyc, got[26:20], got[19:10], got[9:0], exp[26:20], exp[19:10], exp[9:0]);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!va.frame_start && n < 50);
    endtask

    task automatic measure(input int sw_at, input logic pol, output int len, output int de, output int vmin, output int vmax);
        len = 0; de = int'(va.display_en); vmin = 1000; vmax = -1;
        forever begin
            if (va.vsync == pol) begin
                vmin = int'(va.y_coor) < vmin ? int'(va.y_coor) : vmin;
                vmax = int'(va.y_coor) > vmax ? int'(va.y_coor) : vmax;
            end
            @(negedge clk); len++;
            if (va.frame_start || len >= 5000) break;
            de += int'(va.display_en);
            if (len == sw_at) va.mode_sel = 1'b1;
            if (sw_at > 0 && len == sw_at + 100) chk("mode_hold", int'(va.mode_act), 0);
        end
    endtask

    initial begin
        int n, len, de, vmin, vmax, hx;
        bit held;
        va.en = 1'b1; va.mode_sel = 1'b0; vb.en = 1'b1; vb.mode_sel = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        wait_fs(n);
        chk("first_fs_clks", n, 4);
        measure(500, 1'b0, len, de, vmin, vmax);
        chk("mode0_frame_clks", len, 1900);
        chk("mode0_de_clks", de, 768);
        chk("mode0_vs_first_y", vmin, 14);
        chk("mode0_vs_last_y", vmax, 15);
        chk("mode_after_wrap", int'(va.mode_act), 1);
        va.mode_sel = 1'b0;
        measure(0, 1'b1, len, de, vmin, vmax);
        chk("mode1_frame_clks", len, 1700);
        chk("mode1_de_clks", de, 640);
        chk("mode1_vs_first_y", vmin, 11);
        chk("mode1_vs_last_y", vmax, 12);
        n = 0;
        while (!(m_p % HT == 5 && m_div == 1) && n < 500) begin @(negedge clk); n++; end
        chk("hold_setup", int'(n < 500), 1);
        hx = m_p % HT;
        va.en = 1'b0;
        held = 1'b1;
        repeat (37) begin
            @(negedge clk);
            held &= int'(va.x_coor) == hx && !va.line_start && !va.frame_start;
        end
        chk("en_hold", int'(held), 1);
        va.en = 1'b1;
        n = 0;
        while (m_p % HT == hx && n < 20) begin @(negedge clk); n++; end
        chk("resume_x", int'(va.x_coor), hx + 1);
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            va.en = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 499) == 0) va.mode_sel = ~va.mode_sel;
            rst_a = $urandom_range(0, 2999) == 0;
        end
        rst_a = 1'b0; va.en = 1'b1; va.mode_sel = 1'b0;
        n = 0;
        while (!(m_mode == 0 && m_p == 14 * HT + 19) && n < 10000) begin @(negedge clk); n++; end
        chk("sync_setup", int'(va.hsync == 1'b0 && va.vsync == 1'b0), 1);
        rst_a = 1'b1;
        @(negedge clk);
        chk("rst_hsync_idle", int'(va.hsync), 1);
        chk("rst_vsync_idle", int'(va.vsync), 1);
        chk("rst_x", int'(va.x_coor), 24);
        chk("rst_y", int'(va.y_coor), 18);
        rst_a = 1'b0;
        wait_fs(n);
        chk("fs_after_rst_clks", n, 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
